// File: rtl/path_job_scheduler_if.sv
// path_job_scheduler_if
//   Bundles the request, CPU-driver and path-stream signals of the path job
//   scheduler. Clock and reset are kept outside the interface.
//   master : scheduler side (drives acks, CPU control, path stream, status)
//   slave  : environment side (requesters, CPU driver, path consumer)
interface path_job_scheduler_if #(
   parameter int NODE_W  = 5,
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*NODE_W-1:0] req_ep;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NODE_W-1:0]         realtime_pos;
   logic                      cpu_reset;
   logic                      cpu_start;
   logic [NODE_W-1:0]         SP;
   logic [NODE_W-1:0]         EP;
   logic                      cpu_node_valid;
   logic [NODE_W-1:0]         cpu_node;
   logic                      cpu_stop;
   logic                      path_valid;
   logic [NODE_W-1:0]         path_node;
   logic                      path_last;
   logic                      path_ready;
   logic                      busy;
   logic [ID_W-1:0]           active_id;
   logic                      err_timeout;
   logic                      err_overflow;

   modport master (
      input  req_valid, req_ep, realtime_pos, cpu_node_valid, cpu_node, cpu_stop, path_ready,
      output req_ack, cpu_reset, cpu_start, SP, EP, path_valid, path_node, path_last,
             busy, active_id, err_timeout, err_overflow
   );

   modport slave (
      output req_valid, req_ep, realtime_pos, cpu_node_valid, cpu_node, cpu_stop, path_ready,
      input  req_ack, cpu_reset, cpu_start, SP, EP, path_valid, path_node, path_last,
             busy, active_id, err_timeout, err_overflow
   );
endinterface

// File: rtl/path_job_scheduler.sv
// path_job_scheduler
//   Round-robin scheduler of path-planning jobs onto the RISC-V planner.
//   Grants one requester at a time, runs the CPU for one job, buffers the
//   planned nodes and streams them out with valid/ready. Hung CPUs are caught
//   by a timeout; trivial jobs (start == end) bypass the CPU.
//   Ports: clk_50M, rst_n (async, active-low), bus (path_job_scheduler_if.master)
//
// state   | meaning
// IDLE    | waiting for a request, CPU held in reset
// START   | one-cycle CPU start pulse, buffer/timer cleared
// PLAN    | CPU running, nodes captured into the buffer
// DRAIN   | streaming buffered path (or single EP beat) to the consumer
// ERR     | planning timed out, buffer discarded
module path_job_scheduler #(
   parameter int NODE_W         = 5,
   parameter int NUM_REQ        = 4,
   parameter int PATH_DEPTH     = 32,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input logic                  clk_50M,
   input logic                  rst_n,
   path_job_scheduler_if.master bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(PATH_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(PATH_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_PLAN, S_DRAIN, S_ERR} state_t;

   state_t             state_q;
   logic [ID_W-1:0]    rr_q, active_id_q;
   logic [NUM_REQ-1:0] req_ack_q;
   logic [NODE_W-1:0]  sp_q, ep_q, path_node_q;
   logic               cpu_reset_q, cpu_start_q, path_valid_q, path_last_q, busy_q;
   logic               err_timeout_q, err_overflow_q;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [NODE_W-1:0]  mem_q [PATH_DEPTH];

   logic               any_req;
   logic [ID_W-1:0]    win_id, rr_next;
   logic [NODE_W-1:0]  win_ep;
   logic               wr_en;
   logic [CNT_W-1:0]   plan_cnt;
   int                 idx;

   // first asserted channel at or after rr, searching upward with wrap
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_q) + i) % NUM_REQ;
         if (!any_req && bus.req_valid[idx]) begin
            any_req = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
      rr_next = ID_W'((int'(win_id) + 1) % NUM_REQ);
      win_ep  = bus.req_ep[int'(win_id)*NODE_W +: NODE_W];
   end

   assign wr_en    = (state_q == S_PLAN) && bus.cpu_node_valid && (cnt_q != FULL);
   assign plan_cnt = cnt_q + {{(CNT_W-1){1'b0}}, wr_en};

   always_ff @(posedge clk_50M) begin
      if (wr_en) mem_q[wr_ptr_q] <= bus.cpu_node;
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         rr_q           <= '0;
         active_id_q    <= '0;
         req_ack_q      <= '0;
         sp_q           <= '0;
         ep_q           <= '0;
         path_node_q    <= '0;
         cpu_reset_q    <= 1'b1;
         cpu_start_q    <= 1'b0;
         path_valid_q   <= 1'b0;
         path_last_q    <= 1'b0;
         busy_q         <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         cnt_q          <= '0;
         tmo_q          <= '0;
      end else begin
         req_ack_q   <= '0;
         cpu_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  active_id_q    <= win_id;
                  sp_q           <= bus.realtime_pos;
                  ep_q           <= win_ep;
                  req_ack_q      <= NUM_REQ'(1) << win_id;
                  err_timeout_q  <= 1'b0;
                  err_overflow_q <= 1'b0;
                  rr_q           <= rr_next;
                  busy_q         <= 1'b1;
                  wr_ptr_q       <= '0;
                  rd_ptr_q       <= '0;
                  if (bus.realtime_pos == win_ep) begin
                     // trivial job: one synthetic beat carrying EP
                     state_q      <= S_DRAIN;
                     path_valid_q <= 1'b1;
                     path_node_q  <= win_ep;
                     path_last_q  <= 1'b1;
                     cnt_q        <= CNT_W'(1);
                  end else begin
                     state_q     <= S_START;
                     cpu_start_q <= 1'b1;
                     cpu_reset_q <= 1'b0;
                     cnt_q       <= '0;
                  end
               end
            end
            S_START: begin
               state_q  <= S_PLAN;
               cnt_q    <= '0;
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               tmo_q    <= '0;
            end
            S_PLAN: begin
               tmo_q <= tmo_q + TMO_W'(1);
               if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               if (bus.cpu_node_valid && (cnt_q == FULL)) err_overflow_q <= 1'b1;
               if (bus.cpu_stop) begin
                  state_q      <= S_DRAIN;
                  cpu_reset_q  <= 1'b1;
                  path_valid_q <= 1'b1;
                  if (plan_cnt == '0) begin
                     path_node_q <= ep_q;
                     path_last_q <= 1'b1;
                     cnt_q       <= CNT_W'(1);
                  end else begin
                     // a node written on this same edge is not yet readable
                     path_node_q <= (cnt_q == '0) ? bus.cpu_node : mem_q[rd_ptr_q];
                     path_last_q <= (plan_cnt == CNT_W'(1));
                     cnt_q       <= plan_cnt;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  state_q       <= S_ERR;
                  err_timeout_q <= 1'b1;
                  cpu_reset_q   <= 1'b1;
                  cnt_q         <= '0;
               end else begin
                  cnt_q <= plan_cnt;
               end
            end
            S_DRAIN: begin
               if (bus.path_ready) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q      <= S_IDLE;
                     path_valid_q <= 1'b0;
                     path_last_q  <= 1'b0;
                     busy_q       <= 1'b0;
                     cnt_q        <= '0;
                  end else begin
                     path_node_q <= mem_q[rd_ptr_q + PTR_W'(1)];
                     rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                     cnt_q       <= cnt_q - CNT_W'(1);
                     path_last_q <= (cnt_q == CNT_W'(2));
                  end
               end
            end
            S_ERR: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               cnt_q    <= '0;
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ack      = req_ack_q;
   assign bus.cpu_reset    = cpu_reset_q;
   assign bus.cpu_start    = cpu_start_q;
   assign bus.SP           = sp_q;
   assign bus.EP           = ep_q;
   assign bus.path_valid   = path_valid_q;
   assign bus.path_node    = path_node_q;
   assign bus.path_last    = path_last_q;
   assign bus.busy         = busy_q;
   assign bus.active_id    = active_id_q;
   assign bus.err_timeout  = err_timeout_q;
   assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_path_job_scheduler.sv
module tb_path_job_scheduler;
   localparam int NODE_W = 5;
   localparam int NUM_REQ = 4;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   logic [NODE_W-1:0] got_node [16];
   logic              got_last [16];
   int                n_beats;

   path_job_scheduler_if #(.NODE_W(NODE_W), .NUM_REQ(NUM_REQ)) bus ();

   path_job_scheduler #(
      .NODE_W(NODE_W), .NUM_REQ(NUM_REQ), .PATH_DEPTH(4), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk_50M(clk_50M),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50M);
      #1;
   endtask

   // ready held high (toggle=0) or alternating starting low (toggle=1)
   task automatic run_drain(input bit toggle);
      bit                prev_stall, done, rdy;
      logic [NODE_W-1:0] prev_node;
      logic              prev_last;
      n_beats    = 0;
      done       = 1'b0;
      prev_stall = 1'b0;
      prev_node  = '0;
      prev_last  = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (prev_stall) begin
            chk("hold_valid", bus.path_valid, 1);
            chk("hold_node", bus.path_node, prev_node);
            chk("hold_last", bus.path_last, prev_last);
         end
         rdy = toggle ? c[0] : 1'b1;
         bus.path_ready = rdy;
         prev_stall = bus.path_valid && !rdy;
         prev_node  = bus.path_node;
         prev_last  = bus.path_last;
         if (bus.path_valid && rdy) begin
            if (n_beats < 16) begin
               got_node[n_beats] = bus.path_node;
               got_last[n_beats] = bus.path_last;
            end
            n_beats++;
            if (bus.path_last) done = 1'b1;
         end
         tick();
      end
      bus.path_ready = 1'b0;
      if (!done) chk("drain_bound", 0, 1);
   endtask

   int exp_rr [4] = '{0, 2, 3, 0};

   initial begin
      bus.req_valid      = '0;
      bus.req_ep         = '0;
      bus.realtime_pos   = '0;
      bus.cpu_node_valid = 1'b0;
      bus.cpu_node       = '0;
      bus.cpu_stop       = 1'b0;
      bus.path_ready     = 1'b0;

      // reset values
      repeat (3) @(posedge clk_50M);
      #1;
      chk("rst_cpu_reset", bus.cpu_reset, 1);
      chk("rst_cpu_start", bus.cpu_start, 0);
      chk("rst_req_ack", bus.req_ack, 0);
      chk("rst_path_valid", bus.path_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_errs", {bus.err_timeout, bus.err_overflow}, 0);
      chk("rst_sp_ep", {bus.SP, bus.EP}, 0);
      rst_n = 1'b1;
      tick();

      // round-robin with trivial jobs, ch0/2/3 held requesting
      bus.realtime_pos = 5'd9;
      bus.req_ep       = {5'd9, 5'd9, 5'd9, 5'd9};
      bus.req_valid    = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_ack", bus.req_ack, 32'd1 << exp_rr[k]);
         chk("rr_active_id", bus.active_id, exp_rr[k]);
         chk("rr_path_valid", bus.path_valid, 1);
         chk("rr_path_node", bus.path_node, 9);
         chk("rr_cpu_start", bus.cpu_start, 0);
         bus.path_ready = 1'b1;
         tick();
         chk("rr_busy_low", bus.busy, 0);
         bus.path_ready = 1'b0;
      end
      bus.req_valid = '0;
      tick();

      // single job: ch1, SP=3, EP=10, path 3,7,10
      bus.realtime_pos = 5'd3;
      bus.req_ep       = '0;
      bus.req_ep[1*NODE_W +: NODE_W] = 5'd10;
      bus.req_valid    = 4'b0010;
      tick();
      chk("sj_ack", bus.req_ack, 4'b0010);
      chk("sj_sp", bus.SP, 3);
      chk("sj_ep", bus.EP, 10);
      chk("sj_busy", bus.busy, 1);
      chk("sj_cpu_start", bus.cpu_start, 1);
      chk("sj_cpu_reset", bus.cpu_reset, 0);
      bus.req_valid = '0;
      tick();
      chk("sj_start_pulse_end", bus.cpu_start, 0);
      chk("sj_ack_pulse_end", bus.req_ack, 0);
      bus.cpu_node_valid = 1'b1;
      bus.cpu_node = 5'd3;  tick();
      bus.cpu_node = 5'd7;  tick();
      bus.cpu_node = 5'd10; tick();
      bus.cpu_node_valid = 1'b0;
      bus.cpu_stop = 1'b1;
      tick();
      bus.cpu_stop = 1'b0;
      chk("sj_path_valid", bus.path_valid, 1);
      chk("sj_drain_cpu_reset", bus.cpu_reset, 1);
      run_drain(1'b0);
      chk("sj_beats", n_beats, 3);
      chk("sj_n0", got_node[0], 3);
      chk("sj_n1", got_node[1], 7);
      chk("sj_n2", got_node[2], 10);
      chk("sj_lasts", {got_last[0], got_last[1], got_last[2]}, 3'b001);
      chk("sj_busy_low", bus.busy, 0);

      // trivial job: ch2, pos=ep=5
      bus.realtime_pos = 5'd5;
      bus.req_ep       = '0;
      bus.req_ep[2*NODE_W +: NODE_W] = 5'd5;
      bus.req_valid    = 4'b0100;
      tick();
      chk("tr_ack", bus.req_ack, 4'b0100);
      chk("tr_cpu_start", bus.cpu_start, 0);
      chk("tr_cpu_reset", bus.cpu_reset, 1);
      chk("tr_path_valid", bus.path_valid, 1);
      bus.req_valid = '0;
      run_drain(1'b0);
      chk("tr_beats", n_beats, 1);
      chk("tr_node", got_node[0], 5);
      chk("tr_last", got_last[0], 1);

      // timeout: ch3, no cpu_stop
      bus.realtime_pos = 5'd1;
      bus.req_ep       = '0;
      bus.req_ep[3*NODE_W +: NODE_W] = 5'd20;
      bus.req_valid    = 4'b1000;
      tick();
      chk("to_ack", bus.req_ack, 4'b1000);
      bus.req_valid = '0;
      tick();
      repeat (99) tick();
      chk("to_not_yet", bus.err_timeout, 0);
      chk("to_cpu_run", bus.cpu_reset, 0);
      tick();
      chk("to_err", bus.err_timeout, 1);
      chk("to_cpu_reset", bus.cpu_reset, 1);
      chk("to_no_path", bus.path_valid, 0);
      tick();
      chk("to_idle", bus.busy, 0);
      chk("to_no_path_idle", bus.path_valid, 0);
      chk("to_sticky", bus.err_timeout, 1);

      // overflow + backpressure: ch0, 6 nodes into depth 4
      bus.realtime_pos = 5'd2;
      bus.req_ep       = '0;
      bus.req_ep[0 +: NODE_W] = 5'd30;
      bus.req_valid    = 4'b0001;
      tick();
      chk("ov_ack", bus.req_ack, 4'b0001);
      chk("ov_to_cleared", bus.err_timeout, 0);
      bus.req_valid = '0;
      tick();
      for (int n = 0; n < 6; n++) begin
         bus.cpu_node_valid = 1'b1;
         bus.cpu_node = NODE_W'(11 + n);
         bus.cpu_stop = (n == 5);
         tick();
      end
      bus.cpu_node_valid = 1'b0;
      bus.cpu_stop = 1'b0;
      chk("ov_flag", bus.err_overflow, 1);
      chk("ov_path_valid", bus.path_valid, 1);
      run_drain(1'b1);
      chk("ov_beats", n_beats, 4);
      for (int n = 0; n < 4; n++) begin
         chk("ov_node", got_node[n], 11 + n);
         chk("ov_last", got_last[n], (n == 3) ? 1 : 0);
      end
      chk("ov_sticky", bus.err_overflow, 1);

      // reset mid-PLAN: ch2 job, then all channels request after reset
      bus.realtime_pos = 5'd6;
      bus.req_ep       = '0;
      bus.req_ep[2*NODE_W +: NODE_W] = 5'd12;
      bus.req_valid    = 4'b0100;
      tick();
      chk("mr_ack", bus.req_ack, 4'b0100);
      bus.req_valid = '0;
      tick();
      bus.cpu_node_valid = 1'b1;
      bus.cpu_node = 5'd6;
      tick();
      chk("mr_in_plan", bus.cpu_reset, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_cpu_reset", bus.cpu_reset, 1);
      chk("mr_busy", bus.busy, 0);
      chk("mr_sp_ep", {bus.SP, bus.EP}, 0);
      chk("mr_active_id", bus.active_id, 0);
      chk("mr_errs", {bus.err_timeout, bus.err_overflow}, 0);
      chk("mr_path_valid", bus.path_valid, 0);
      #2 rst_n = 1'b1;
      bus.cpu_node_valid = 1'b0;
      bus.realtime_pos = 5'd4;
      bus.req_ep       = {5'd4, 5'd4, 5'd4, 5'd4};
      bus.req_valid    = 4'b1111;
      tick();
      chk("mr_regrant_ack", bus.req_ack, 4'b0001);
      chk("mr_regrant_id", bus.active_id, 0);
      bus.req_valid = '0;
      run_drain(1'b0);
      chk("mr_beats", n_beats, 1);
      chk("mr_node", got_node[0], 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
